leaf_oct_arbiter: RTL and testbench

LEAF_OCT_ARBITER -- requirements
Module: leaf_oct_arbiter

---
 rtl/leaf_oct_arbiter.sv | 99 +++++++++
 tb/tb_leaf_oct_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/leaf_oct_arbiter.sv
// Round-robin merge of NUM_LEAF leaf packet streams into one BFT output port.
// Each leaf has a one-entry holding buffer; the output register honours out_stall backpressure.
module leaf_oct_arbiter #(
    parameter int unsigned NUM_LEAF = 8,
    parameter int unsigned PKT_W    = 49
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_LEAF*PKT_W-1:0] din_leaf_interface2bft,
    output logic [NUM_LEAF-1:0]       in_ready,
    output logic [PKT_W-1:0]          dout_arb2bft,
    input  logic                      out_stall,
    output logic [15:0]               pkt_cnt
);

    localparam int unsigned PTR_W = (NUM_LEAF > 1) ? $clog2(NUM_LEAF) : 1;
    localparam int unsigned CNT_W = 16;

    logic [NUM_LEAF-1:0] buf_vld_q, buf_vld_d;
    logic [PKT_W-1:0]    buf_data_q [NUM_LEAF];
    logic [PKT_W-1:0]    buf_data_d [NUM_LEAF];
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PKT_W-1:0]    dout_q, dout_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic                out_free;

    // Round-robin search: scan from furthest to nearest so the nearest set buffer after ptr wins.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = int'(NUM_LEAF); k >= 1; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(NUM_LEAF)) begin
                idx = idx - int'(NUM_LEAF);
            end
            if (buf_vld_q[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    assign out_free = ~dout_q[PKT_W-1] | ~out_stall;

    // Capture into empty buffers, then grant one full buffer when the output register is free.
    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_data_d = buf_data_q;
        ptr_d      = ptr_q;
        dout_d     = dout_q;
        cnt_d      = cnt_q;

        for (int unsigned i = 0; i < NUM_LEAF; i++) begin
            if (!buf_vld_q[i] && din_leaf_interface2bft[i*PKT_W + PKT_W - 1]) begin
                buf_vld_d[i]  = 1'b1;
                buf_data_d[i] = din_leaf_interface2bft[i*PKT_W +: PKT_W];
            end
        end

        if (out_free) begin
            if (win_found) begin
                dout_d             = buf_data_q[win_idx];
                buf_vld_d[win_idx] = 1'b0;
                ptr_d              = win_idx;
                cnt_d              = CNT_W'(cnt_q + CNT_W'(1));
            end else begin
                dout_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_vld_q <= '0;
            ptr_q     <= PTR_W'(NUM_LEAF - 1);
            dout_q    <= '0;
            cnt_q     <= '0;
            for (int unsigned i = 0; i < NUM_LEAF; i++) begin
                buf_data_q[i] <= '0;
            end
        end else begin
            buf_vld_q  <= buf_vld_d;
            buf_data_q <= buf_data_d;
            ptr_q      <= ptr_d;
            dout_q     <= dout_d;
            cnt_q      <= cnt_d;
        end
    end

    // in_ready is forced low combinationally so reset takes effect without a clock edge.
    assign in_ready     = reset ? '0 : ~buf_vld_q;
    assign dout_arb2bft = dout_q;
    assign pkt_cnt      = cnt_q;

endmodule

// File: tb/tb_leaf_oct_arbiter.sv
// Directed bench for leaf_oct_arbiter: latency, ordering, stall, fairness, reset and counter wrap.
module tb_leaf_oct_arbiter;

    localparam int unsigned NL = 8;
    localparam int unsigned PW = 49;

    logic               clk;
    logic               reset;
    logic [NL*PW-1:0]   din;
    logic [NL-1:0]      in_ready;
    logic [PW-1:0]      dout;
    logic               out_stall;
    logic [15:0]        pkt_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    leaf_oct_arbiter #(.NUM_LEAF(NL), .PKT_W(PW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .din_leaf_interface2bft (din),
        .in_ready               (in_ready),
        .dout_arb2bft           (dout),
        .out_stall              (out_stall),
        .pkt_cnt                (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_leaf(input int i, input logic [PW-1:0] pkt);
        din[i*PW +: PW] = pkt;
    endtask

    function automatic logic [PW-1:0] mk(input logic [47:0] payload);
        return {1'b1, payload};
    endfunction

    initial begin
        int cycles;
        reset     = 1'b1;
        din       = '0;
        out_stall = 1'b0;

        // Reset state
        #2;
        check("rst_in_ready", 64'(in_ready), 64'h0);
        check("rst_dout", 64'(dout), 64'h0);
        check("rst_cnt", 64'(pkt_cnt), 64'h0);
        step();
        step();
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'hFF);

        // Single packet from leaf 3; leaf 6 has data but valid=0
        set_leaf(3, 49'h1_0000_0000_00AB);
        set_leaf(6, 49'h0_1234_5678_9ABC);
        step();
        check("single_capture_ready", 64'(in_ready), 64'hF7);
        check("single_dout_wait", 64'(dout), 64'h0);
        din = '0;
        step();
        check("single_dout", 64'(dout), 64'h1_0000_0000_00AB);
        check("single_cnt", 64'(pkt_cnt), 64'd1);
        check("single_ready_back", 64'(in_ready), 64'hFF);
        step();
        check("single_dout_clear", 64'(dout), 64'h0);
        check("single_cnt_hold", 64'(pkt_cnt), 64'd1);

        // All eight leaves at once after reset: issue order 0..7
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) set_leaf(i, mk(48'h100 + 48'(i)));
        step();
        check("all_capture_ready", 64'(in_ready), 64'h00);
        din = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("all_order_%0d", i), 64'(dout), 64'(mk(48'h100 + 48'(i))));
        end
        check("all_cnt", 64'(pkt_cnt), 64'd8);
        step();
        check("all_dout_clear", 64'(dout), 64'h0);

        // Stall holds output, counter and buffered leaf
        set_leaf(1, mk(48'h111));
        set_leaf(2, mk(48'h222));
        step();
        din = '0;
        step();
        check("stall_first", 64'(dout), 64'(mk(48'h111)));
        check("stall_cnt0", 64'(pkt_cnt), 64'd9);
        out_stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("stall_hold_%0d", c), 64'(dout), 64'(mk(48'h111)));
            check($sformatf("stall_ready_%0d", c), 64'(in_ready), 64'hFB);
            check($sformatf("stall_cnt_%0d", c), 64'(pkt_cnt), 64'd9);
        end
        out_stall = 1'b0;
        step();
        check("stall_release", 64'(dout), 64'(mk(48'h222)));
        check("stall_cnt1", 64'(pkt_cnt), 64'd10);
        step();
        check("stall_dout_clear", 64'(dout), 64'h0);

        // Fairness: leaves 0 and 5 request continuously (ptr is 2, so 5 wins first)
        set_leaf(0, mk(48'hA0));
        set_leaf(5, mk(48'hA5));
        step();
        check("fair_first_empty", 64'(dout), 64'h0);
        for (int g = 0; g < 6; g++) begin
            step();
            check($sformatf("fair_grant_%0d", g), 64'(dout),
                  (g % 2 == 0) ? 64'(mk(48'hA5)) : 64'(mk(48'hA0)));
        end
        check("fair_cnt", 64'(pkt_cnt), 64'd16);
        din = '0;
        step();
        check("fair_drain", 64'(dout), 64'(mk(48'hA5)));
        check("fair_drain_cnt", 64'(pkt_cnt), 64'd17);
        step();
        check("fair_idle", 64'(dout), 64'h0);

        // Reset mid-stream: four buffers full and a valid packet on the output
        for (int i = 1; i <= 6; i++) if (i != 5) set_leaf(i, mk(48'hB0 + 48'(i)));
        step();
        din = '0;
        step();
        check("mid_dout", 64'(dout), 64'(mk(48'hB6)));
        check("mid_ready", 64'(in_ready), 64'hE1);
        check("mid_cnt", 64'(pkt_cnt), 64'd18);
        reset = 1'b1;
        #1;
        check("mid_rst_dout", 64'(dout), 64'h0);
        check("mid_rst_cnt", 64'(pkt_cnt), 64'h0);
        check("mid_rst_ready", 64'(in_ready), 64'h0);
        step();
        step();
        reset = 1'b0;
        #1;
        check("mid_release_ready", 64'(in_ready), 64'hFF);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("mid_no_stale_%0d", c), 64'(dout), 64'h0);
        end
        check("mid_cnt_zero", 64'(pkt_cnt), 64'h0);

        // Counter wrap under continuous traffic from all leaves
        for (int i = 0; i < 8; i++) set_leaf(i, mk(48'hC0 + 48'(i)));
        cycles = 0;
        while (pkt_cnt != 16'hFFFF && cycles < 70000) begin
            step();
            cycles++;
        end
        check("wrap_reach_max", 64'(pkt_cnt), 64'hFFFF);
        step();
        check("wrap_cnt", 64'(pkt_cnt), 64'h0);
        check("wrap_dout_valid", 64'(dout[PW-1]), 64'h1);
        din = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
